tile_boot_ctrl: RTL and testbench
=================================

TILE_BOOT_CTRL -- requirements
Module: tile_boot_ctrl

Interface
REQ-001 SHALL have parameter NumHarts, default 2, number of cluster harts sequenced.
REQ-002 SHALL have parameter RstHoldCycles, default 16, cycles the cluster reset is held asserted.
REQ-003 SHALL have parameter SettleCycles, default 8, cycles between reset release and the first kick.
REQ-004 SHALL have parameter MsipPulseCycles, default 4, width of each per-hart msip pulse.
REQ-005 SHALL have parameter DrainTimeout, default 1024, maximum number of cycles spent waiting for NoC traffic to drain.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port test_enable_i, input, 1 bit: test-mode override.
REQ-009 SHALL have port boot_req_i, input, 1 bit: single-cycle boot request.
REQ-010 SHALL have port boot_hart_mask_i, input, NumHarts bits: harts to kick, sampled when boot_req_i is accepted.
REQ-011 SHALL have port halt_req_i, input, 1 bit: halt request.
REQ-012 SHALL have port narrow_busy_i, input, 1 bit: narrow NI has outstanding transactions.
REQ-013 SHALL have port wide_busy_i, input, 1 bit: wide NI has outstanding transactions.
REQ-014 SHALL have port cluster_rst_no, output, 1 bit: cluster reset, active-low.
REQ-015 SHALL have port msip_o, output, NumHarts bits: software-interrupt kick to each hart.
REQ-016 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-017 SHALL have port boot_done_o, output, 1 bit: high while the FSM is in RUN.
REQ-018 SHALL have port halt_done_o, output, 1 bit: one-cycle pulse on entry to OFF from DRAIN.
REQ-019 SHALL have port err_timeout_o, output, 1 bit: sticky drain-timeout flag.

Function
REQ-020 SHALL implement FSM states OFF, RST_HOLD, SETTLE, KICK, RUN, DRAIN, all registered.
REQ-021 SHALL move OFF->RST_HOLD on boot_req_i=1 with halt_req_i=0, latching boot_hart_mask_i and clearing err_timeout_o.
REQ-022 SHALL stay in OFF when boot_req_i and halt_req_i are both 1 (halt wins).
REQ-023 SHALL hold cluster_rst_no=0 in OFF and RST_HOLD, and drive it to 1 in every other state.
REQ-024 SHALL leave RST_HOLD after exactly RstHoldCycles cycles, and SETTLE after exactly SettleCycles cycles.
REQ-025 SHALL enter RUN directly from SETTLE when the latched mask is zero.
REQ-026 SHALL kick in KICK one hart at a time, lowest index first, skipping unmasked harts at zero cycle cost, driving that hart's msip_o bit for MsipPulseCycles cycles.
REQ-027 SHALL enter RUN in the cycle after the last masked pulse ends; msip_o is one-hot or zero at all times.
REQ-028 SHALL ignore boot_req_i in every state except OFF.
REQ-029 SHALL abort to OFF on the next edge when halt_req_i=1 in RST_HOLD, SETTLE or KICK, forcing msip_o=0 and cluster_rst_no=0; halt_done_o is not pulsed.
REQ-030 SHALL move RUN->DRAIN on halt_req_i=1.
REQ-031 SHALL leave DRAIN for OFF once narrow_busy_i=0 and wide_busy_i=0 have held for 4 consecutive cycles, pulsing halt_done_o.
REQ-032 SHALL leave DRAIN for OFF without halt_done_o, setting err_timeout_o, when DRAIN has lasted DrainTimeout cycles without the 4-cycle idle condition.
REQ-033 SHALL size counters to $clog2 of the largest count plus 1 bit, so that no count wraps.
REQ-034 SHALL, while test_enable_i=1, force cluster_rst_no=1 and msip_o=0 combinationally without changing FSM state.

Reset
REQ-035 SHALL, on rst_ni=0 at a clock edge: state OFF, all counters 0, latched mask 0, cluster_rst_no=0, msip_o=0, boot_done_o=0, halt_done_o=0, err_timeout_o=0.
REQ-036 SHALL give reset asserted mid-sequence (any state) the same result as REQ-035 in that same cycle.

Structure
REQ-037 SHALL take the state enum tile_boot_state_e and the default parameter constants from the shared package floo_tile_pkg.
REQ-038 SHALL use one sub-module, tile_boot_timer: a loadable down-counter with a zero flag, reused for hold, settle, pulse and timeout counting.

Verification
REQ-039 SHALL cover boot with mask 2'b11 accepted at cycle 0: cluster_rst_no=0 for cycles 1-16, =1 from cycle 17; msip_o=01 cycles 25-28, =10 cycles 29-32; boot_done_o=1 from cycle 33.
REQ-040 SHALL cover boot with mask 2'b10: msip_o=10 cycles 25-28, RUN at cycle 29; with mask 2'b00: RUN at cycle 25, msip_o never nonzero.
REQ-041 SHALL cover halt_req_i at cycle 26 during KICK: OFF at cycle 27, msip_o=0, cluster_rst_no=0, halt_done_o stays 0.
REQ-042 SHALL cover halt in RUN with both busy inputs low: DRAIN then OFF after 4 idle cycles, halt_done_o a single-cycle pulse.
REQ-043 SHALL cover halt in RUN with narrow_busy_i stuck at 1: OFF after 1024 DRAIN cycles, err_timeout_o=1 until the next accepted boot_req_i.
REQ-044 SHALL cover rst_ni=0 during SETTLE: all outputs equal the REQ-035 values in the following cycle, and boot_req_i with halt_req_i both high in OFF leaves the FSM in OFF.

Source files
------------

// File: rtl/floo_tile_pkg.sv
// Shared state encoding and default timing constants for the tile boot controller.
package floo_tile_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_KICK     = 3'd3,
        ST_RUN      = 3'd4,
        ST_DRAIN    = 3'd5
    } tile_boot_state_e;

    localparam int unsigned DefNumHarts        = 2;
    localparam int unsigned DefRstHoldCycles   = 16;
    localparam int unsigned DefSettleCycles    = 8;
    localparam int unsigned DefMsipPulseCycles = 4;
    localparam int unsigned DefDrainTimeout    = 1024;
    // Both NoC interfaces must be quiet this many consecutive cycles to finish a drain.
    localparam int unsigned DrainIdleCycles    = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tile_boot_timer.sv
// Loadable down-counter with a zero flag; saturates at zero when not reloaded.
module tile_boot_timer #(
    parameter int unsigned Width = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    output logic             o_zero
);

    logic [Width-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/tile_boot_ctrl.sv
// Cluster boot/halt sequencer: reset hold, settle, per-hart msip kicks, and NoC drain on halt.
module tile_boot_ctrl
    import floo_tile_pkg::*;
#(
    parameter int unsigned NumHarts        = DefNumHarts,
    parameter int unsigned RstHoldCycles   = DefRstHoldCycles,
    parameter int unsigned SettleCycles    = DefSettleCycles,
    parameter int unsigned MsipPulseCycles = DefMsipPulseCycles,
    parameter int unsigned DrainTimeout    = DefDrainTimeout
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_enable_i,
    input  logic                boot_req_i,
    input  logic [NumHarts-1:0] boot_hart_mask_i,
    input  logic                halt_req_i,
    input  logic                narrow_busy_i,
    input  logic                wide_busy_i,
    output logic                cluster_rst_no,
    output logic [NumHarts-1:0] msip_o,
    output logic [2:0]          state_o,
    output logic                boot_done_o,
    output logic                halt_done_o,
    output logic                err_timeout_o
);

    localparam int unsigned MaxCount = max_u(max_u(RstHoldCycles, SettleCycles),
                                             max_u(MsipPulseCycles, DrainTimeout));
    localparam int unsigned TmrW     = $clog2(MaxCount) + 1;
    localparam int unsigned IdxW     = (NumHarts > 1) ? $clog2(NumHarts) : 1;
    localparam int unsigned IdleW    = $clog2(DrainIdleCycles) + 1;
    localparam logic [NumHarts-1:0] HartOne  = NumHarts'(1);
    localparam logic [IdleW-1:0]    IdleLast = IdleW'(DrainIdleCycles - 1);

    tile_boot_state_e    r_state;
    logic [NumHarts-1:0] r_mask;
    logic [NumHarts-1:0] r_msip;
    logic [IdxW-1:0]     r_hart_idx;
    logic [IdleW-1:0]    r_idle_cnt;
    logic                r_rst_n;
    logic                r_boot_done;
    logic                r_halt_done;
    logic                r_err;

    logic                w_tmr_load;
    logic [TmrW-1:0]     w_tmr_val;
    logic                w_tmr_zero;
    logic                w_first_vld;
    logic [IdxW-1:0]     w_first_idx;
    logic                w_next_vld;
    logic [IdxW-1:0]     w_next_idx;
    logic                w_idle;

    assign w_idle = !narrow_busy_i && !wide_busy_i;

    // Lowest masked hart overall, and lowest masked hart above the one being kicked.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int i = NumHarts - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = IdxW'(i);
                if (i > int'(r_hart_idx)) begin
                    w_next_vld = 1'b1;
                    w_next_idx = IdxW'(i);
                end
            end
        end
    end

    // The timer is preloaded for the following phase while the current one expires.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_OFF: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TmrW'(RstHoldCycles - 1);
            end
            ST_RST_HOLD: begin
                w_tmr_load = w_tmr_zero;
                w_tmr_val  = TmrW'(SettleCycles - 1);
            end
            ST_SETTLE, ST_KICK: begin
                w_tmr_load = w_tmr_zero;
                w_tmr_val  = TmrW'(MsipPulseCycles - 1);
            end
            ST_RUN: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TmrW'(DrainTimeout - 1);
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    tile_boot_timer #(
        .Width(TmrW)
    ) u_timer (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_OFF;
            r_mask      <= '0;
            r_msip      <= '0;
            r_hart_idx  <= '0;
            r_idle_cnt  <= '0;
            r_rst_n     <= 1'b0;
            r_boot_done <= 1'b0;
            r_halt_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_halt_done <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (boot_req_i && !halt_req_i) begin
                        r_state <= ST_RST_HOLD;
                        r_mask  <= boot_hart_mask_i;
                        r_err   <= 1'b0;
                    end
                end
                ST_RST_HOLD: begin
                    if (halt_req_i) begin
                        r_state <= ST_OFF;
                    end else if (w_tmr_zero) begin
                        r_state <= ST_SETTLE;
                        r_rst_n <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (halt_req_i) begin
                        r_state <= ST_OFF;
                        r_rst_n <= 1'b0;
                    end else if (w_tmr_zero) begin
                        if (w_first_vld) begin
                            r_state    <= ST_KICK;
                            r_hart_idx <= w_first_idx;
                            r_msip     <= HartOne << w_first_idx;
                        end else begin
                            r_state     <= ST_RUN;
                            r_boot_done <= 1'b1;
                        end
                    end
                end
                ST_KICK: begin
                    if (halt_req_i) begin
                        r_state <= ST_OFF;
                        r_rst_n <= 1'b0;
                        r_msip  <= '0;
                    end else if (w_tmr_zero) begin
                        if (w_next_vld) begin
                            r_hart_idx <= w_next_idx;
                            r_msip     <= HartOne << w_next_idx;
                        end else begin
                            r_state     <= ST_RUN;
                            r_msip      <= '0;
                            r_boot_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (halt_req_i) begin
                        r_state     <= ST_DRAIN;
                        r_boot_done <= 1'b0;
                        r_idle_cnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A completed idle window wins over a simultaneous timeout.
                    if (w_idle && (r_idle_cnt == IdleLast)) begin
                        r_state     <= ST_OFF;
                        r_rst_n     <= 1'b0;
                        r_halt_done <= 1'b1;
                    end else if (w_tmr_zero) begin
                        r_state <= ST_OFF;
                        r_rst_n <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_idle_cnt <= w_idle ? (r_idle_cnt + IdleW'(1)) : '0;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_rst_n <= 1'b0;
                    r_msip  <= '0;
                end
            endcase
        end
    end

    assign cluster_rst_no = r_rst_n | test_enable_i;
    assign msip_o         = test_enable_i ? '0 : r_msip;
    assign state_o        = r_state;
    assign boot_done_o    = r_boot_done;
    assign halt_done_o    = r_halt_done;
    assign err_timeout_o  = r_err;

endmodule

// File: tb/tb_tile_boot_ctrl.sv
// Bench for tile_boot_ctrl: timeline-based reference model checked every cycle plus directed literal checks.
module tb_tile_boot_ctrl;
    import floo_tile_pkg::*;

    localparam int NH = 2;
    localparam int H  = 16;
    localparam int S  = 8;
    localparam int P  = 4;
    localparam int T  = 1024;

    localparam int M_OFF   = 0;
    localparam int M_SEQ   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          test_enable_i;
    logic          boot_req_i;
    logic [NH-1:0] boot_hart_mask_i;
    logic          halt_req_i;
    logic          narrow_busy_i;
    logic          wide_busy_i;
    logic          cluster_rst_no;
    logic [NH-1:0] msip_o;
    logic [2:0]    state_o;
    logic          boot_done_o;
    logic          halt_done_o;
    logic          err_timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase, cycles since boot accept, drain length, idle run, latched mask.
    int            m_phase = M_OFF;
    int            m_d     = 0;
    int            m_dl    = 0;
    int            m_idle  = 0;
    logic [NH-1:0] m_mask  = '0;
    logic          m_err   = 1'b0;
    logic          m_hdone = 1'b0;
    logic          m_valid = 1'b0;

    tile_boot_ctrl #(
        .NumHarts        (NH),
        .RstHoldCycles   (H),
        .SettleCycles    (S),
        .MsipPulseCycles (P),
        .DrainTimeout    (T)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .test_enable_i    (test_enable_i),
        .boot_req_i       (boot_req_i),
        .boot_hart_mask_i (boot_hart_mask_i),
        .halt_req_i       (halt_req_i),
        .narrow_busy_i    (narrow_busy_i),
        .wide_busy_i      (wide_busy_i),
        .cluster_rst_no   (cluster_rst_no),
        .msip_o           (msip_o),
        .state_o          (state_o),
        .boot_done_o      (boot_done_o),
        .halt_done_o      (halt_done_o),
        .err_timeout_o    (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int n_set(input logic [NH-1:0] m);
        int n = 0;
        for (int i = 0; i < NH; i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic int kth_set(input logic [NH-1:0] m, input int k);
        int seen = 0;
        for (int i = 0; i < NH; i++) begin
            if (m[i]) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs held during the cycle that just ended.
    task automatic model_step();
        m_hdone = 1'b0;
        if (!rst_ni) begin
            m_phase = M_OFF;
            m_mask  = '0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                M_OFF: begin
                    if (boot_req_i && !halt_req_i) begin
                        m_phase = M_SEQ;
                        m_d     = 1;
                        m_mask  = boot_hart_mask_i;
                        m_err   = 1'b0;
                    end
                end
                M_SEQ: begin
                    if (halt_req_i) begin
                        m_phase = M_OFF;
                    end else begin
                        m_d++;
                        if (m_d > H + S + n_set(m_mask) * P) m_phase = M_RUN;
                    end
                end
                M_RUN: begin
                    if (halt_req_i) begin
                        m_phase = M_DRAIN;
                        m_dl    = 1;
                        m_idle  = 0;
                    end
                end
                default: begin
                    if (!narrow_busy_i && !wide_busy_i) m_idle++;
                    else m_idle = 0;
                    if (m_idle == 4) begin
                        m_phase = M_OFF;
                        m_hdone = 1'b1;
                    end else if (m_dl == T) begin
                        m_phase = M_OFF;
                        m_err   = 1'b1;
                    end else begin
                        m_dl++;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        logic [2:0]    es;
        logic          er;
        logic [NH-1:0] em;
        es = ST_OFF;
        er = 1'b1;
        em = '0;
        case (m_phase)
            M_OFF: begin
                es = ST_OFF;
                er = 1'b0;
            end
            M_SEQ: begin
                if (m_d <= H) begin
                    es = ST_RST_HOLD;
                    er = 1'b0;
                end else if (m_d <= H + S) begin
                    es = ST_SETTLE;
                end else begin
                    es = ST_KICK;
                    em = NH'(1) << kth_set(m_mask, (m_d - H - S - 1) / P);
                end
            end
            M_RUN:   es = ST_RUN;
            default: es = ST_DRAIN;
        endcase
        if (test_enable_i) begin
            er = 1'b1;
            em = '0;
        end
        check("state_o", 32'(state_o), 32'(es));
        check("cluster_rst_no", 32'(cluster_rst_no), 32'(er));
        check("msip_o", 32'(msip_o), 32'(em));
        check("boot_done_o", 32'(boot_done_o), 32'(m_phase == M_RUN));
        check("halt_done_o", 32'(halt_done_o), 32'(m_hdone));
        check("err_timeout_o", 32'(err_timeout_o), 32'(m_err));
    endtask

    always @(posedge clk_i) begin
        model_step();
        #1;
        if (m_valid) compare_all();
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic quiet();
        boot_req_i       = 1'b0;
        halt_req_i       = 1'b0;
        narrow_busy_i    = 1'b0;
        wide_busy_i      = 1'b0;
        test_enable_i    = 1'b0;
        boot_hart_mask_i = '0;
    endtask

    // Let a RUN-state cluster drain with idle NoC and return to OFF.
    task automatic halt_idle(input string tag);
        halt_req_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            halt_req_i = 1'b0;
            if (c == 1) check({tag, "_drain_state"}, 32'(state_o), 32'(ST_DRAIN));
            if (c == 4) check({tag, "_hdone_c4"}, 32'(halt_done_o), 32'd0);
            if (c == 5) check({tag, "_hdone_c5"}, 32'(halt_done_o), 32'd1);
            if (c == 5) check({tag, "_off_c5"}, 32'(state_o), 32'(ST_OFF));
            if (c == 6) check({tag, "_hdone_c6"}, 32'(halt_done_o), 32'd0);
        end
    endtask

    initial begin
        logic stuck;
        rst_ni = 1'b0;
        quiet();
        repeat (3) step();
        check("rst_state", 32'(state_o), 32'(ST_OFF));
        check("rst_cluster_rst", 32'(cluster_rst_no), 32'd0);
        check("rst_msip", 32'(msip_o), 32'd0);
        check("rst_flags", {29'd0, boot_done_o, halt_done_o, err_timeout_o}, 32'd0);
        rst_ni = 1'b1;
        step();

        // Boot both harts; a stray boot request mid-sequence must be ignored.
        boot_req_i = 1'b1;
        boot_hart_mask_i = 2'b11;
        for (int c = 1; c <= 34; c++) begin
            step();
            boot_req_i = (c == 10);
            boot_hart_mask_i = 2'($urandom_range(0, 3));
            if (c == 1)  check("b11_rst_c1", 32'(cluster_rst_no), 32'd0);
            if (c == 16) check("b11_rst_c16", 32'(cluster_rst_no), 32'd0);
            if (c == 17) check("b11_rst_c17", 32'(cluster_rst_no), 32'd1);
            if (c == 24) check("b11_msip_c24", 32'(msip_o), 32'd0);
            if (c == 25) check("b11_msip_c25", 32'(msip_o), 32'b01);
            if (c == 28) check("b11_msip_c28", 32'(msip_o), 32'b01);
            if (c == 29) check("b11_msip_c29", 32'(msip_o), 32'b10);
            if (c == 32) check("b11_msip_c32", 32'(msip_o), 32'b10);
            if (c == 32) check("b11_done_c32", 32'(boot_done_o), 32'd0);
            if (c == 33) check("b11_done_c33", 32'(boot_done_o), 32'd1);
            if (c == 33) check("b11_msip_c33", 32'(msip_o), 32'd0);
        end
        halt_idle("h1");

        // Boot hart 1 only, then drain with narrow NI stuck busy.
        boot_req_i = 1'b1;
        boot_hart_mask_i = 2'b10;
        for (int c = 1; c <= 30; c++) begin
            step();
            boot_req_i = 1'b0;
            if (c == 25) check("b10_msip_c25", 32'(msip_o), 32'b10);
            if (c == 28) check("b10_done_c28", 32'(boot_done_o), 32'd0);
            if (c == 29) check("b10_state_c29", 32'(state_o), 32'(ST_RUN));
        end
        narrow_busy_i = 1'b1;
        halt_req_i = 1'b1;
        for (int c = 1; c <= 1030; c++) begin
            step();
            halt_req_i = 1'b0;
            if (c == 1024) check("to_state_c1024", 32'(state_o), 32'(ST_DRAIN));
            if (c == 1024) check("to_err_c1024", 32'(err_timeout_o), 32'd0);
            if (c == 1025) check("to_state_c1025", 32'(state_o), 32'(ST_OFF));
            if (c == 1025) check("to_err_c1025", 32'(err_timeout_o), 32'd1);
            if (c == 1025) check("to_hdone_c1025", 32'(halt_done_o), 32'd0);
            if (c == 1030) check("to_err_c1030", 32'(err_timeout_o), 32'd1);
        end
        narrow_busy_i = 1'b0;

        // Empty mask: straight to RUN, no kicks; the accepted boot clears the error flag.
        boot_req_i = 1'b1;
        boot_hart_mask_i = 2'b00;
        for (int c = 1; c <= 26; c++) begin
            step();
            boot_req_i = 1'b0;
            check("b00_msip", 32'(msip_o), 32'd0);
            if (c == 1)  check("b00_err_c1", 32'(err_timeout_o), 32'd0);
            if (c == 24) check("b00_state_c24", 32'(state_o), 32'(ST_SETTLE));
            if (c == 25) check("b00_state_c25", 32'(state_o), 32'(ST_RUN));
        end
        halt_idle("h2");

        // Halt in the middle of the kick phase.
        boot_req_i = 1'b1;
        boot_hart_mask_i = 2'b11;
        for (int c = 1; c <= 28; c++) begin
            step();
            boot_req_i = 1'b0;
            halt_req_i = 1'b0;
            if (c == 26) begin
                check("hk_msip_c26", 32'(msip_o), 32'b01);
                halt_req_i = 1'b1;
            end
            if (c == 27) begin
                check("hk_state_c27", 32'(state_o), 32'(ST_OFF));
                check("hk_msip_c27", 32'(msip_o), 32'd0);
                check("hk_rst_c27", 32'(cluster_rst_no), 32'd0);
                check("hk_hdone_c27", 32'(halt_done_o), 32'd0);
            end
            if (c == 28) check("hk_hdone_c28", 32'(halt_done_o), 32'd0);
        end

        // Test-mode override, reset during SETTLE, then boot+halt together in OFF.
        boot_req_i = 1'b1;
        boot_hart_mask_i = 2'b01;
        for (int c = 1; c <= 23; c++) begin
            step();
            boot_req_i = 1'b0;
            halt_req_i = 1'b0;
            rst_ni = 1'b1;
            if (c == 5) test_enable_i = 1'b1;
            if (c == 6) begin
                check("te_rst_forced", 32'(cluster_rst_no), 32'd1);
                check("te_state_kept", 32'(state_o), 32'(ST_RST_HOLD));
                test_enable_i = 1'b0;
            end
            if (c == 20) rst_ni = 1'b0;
            if (c == 21) begin
                check("mr_state", 32'(state_o), 32'(ST_OFF));
                check("mr_outputs", {27'd0, cluster_rst_no, msip_o, boot_done_o, halt_done_o},
                      32'd0);
                check("mr_err", 32'(err_timeout_o), 32'd0);
            end
            if (c == 22) begin
                boot_req_i = 1'b1;
                halt_req_i = 1'b1;
            end
            if (c == 23) check("bh_state_off", 32'(state_o), 32'(ST_OFF));
        end

        // Randomized traffic checked by the model every cycle.
        stuck = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 799) == 0) stuck = ~stuck;
            rst_ni           = ($urandom_range(0, 599) != 0);
            boot_req_i       = ($urandom_range(0, 15) == 0);
            boot_hart_mask_i = 2'($urandom_range(0, 3));
            halt_req_i       = ($urandom_range(0, 49) == 0);
            narrow_busy_i    = stuck || ($urandom_range(0, 2) == 0);
            wide_busy_i      = ($urandom_range(0, 3) == 0);
            test_enable_i    = ($urandom_range(0, 39) == 0);
        end
        rst_ni = 1'b1;
        quiet();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
